// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/issue and execute stages:
// opcodes, type codes, instruction field positions and operand-use decode.
package isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_PB   = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [1:0] TYPE_SIGNED = 2'd0;
    localparam logic [1:0] TYPE_BYTE   = 2'd1;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int TYPE_MSB = 11;
    localparam int TYPE_LSB = 10;
    localparam int RD_MSB   = 9;
    localparam int RD_LSB   = 7;
    localparam int RA_MSB   = 6;
    localparam int RA_LSB   = 4;
    localparam int RB_MSB   = 3;
    localparam int RB_LSB   = 1;

    typedef struct packed {
        logic use_a;
        logic use_b;
        logic issue;     // produces a packet and claims rd
        logic illegal;
    } use_t;

    function automatic use_t decode_use(input logic [3:0] op);
        use_t u;
        u.use_a   = (op <= OP_NOT);
        u.use_b   = (op <= OP_SLTU) || (op == OP_PB);
        u.issue   = (op <= OP_PB);
        u.illegal = (op > OP_PB) && (op != OP_NOP);
        return u;
    endfunction

endpackage

// File: rtl/decode_issue_unit_if.sv
// Instruction, writeback and issue-packet signals of the decode/issue stage.
interface decode_issue_unit_if #(parameter int DATA_W = 16);

    logic              flush_i;
    logic              instr_valid_i;
    logic [15:0]       instr_i;
    logic              instr_ready_o;
    logic              wb_en_i;
    logic [2:0]        wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [3:0]        dec_op_o;
    logic [1:0]        dec_type_o;
    logic [DATA_W-1:0] dec_a_o;
    logic [DATA_W-1:0] dec_b_o;
    logic [2:0]        dec_rd_o;
    logic              illegal_o;

    modport slave (
        input  flush_i, instr_valid_i, instr_i, wb_en_i, wb_addr_i, wb_data_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, dec_op_o, dec_type_o, dec_a_o, dec_b_o, dec_rd_o,
               illegal_o
    );

    modport master (
        output flush_i, instr_valid_i, instr_i, wb_en_i, wb_addr_i, wb_data_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, dec_op_o, dec_type_o, dec_a_o, dec_b_o, dec_rd_o,
               illegal_o
    );

endinterface

// File: rtl/regfile_2r1w.sv
// 8-entry register file, two async read ports, one write port, r0 hardwired to zero,
// optional forwarding of the write port onto the read ports.
module regfile_2r1w #(
    parameter int DATA_W    = 16,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [2:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [8];
    logic [DATA_W-1:0] mem_d [8];
    logic              fwd_a;
    logic              fwd_b;

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != 3'd0)) mem_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        fwd_a = (BYPASS_EN != 0) && we_i && (waddr_i == raddr_a_i);
        fwd_b = (BYPASS_EN != 0) && we_i && (waddr_i == raddr_b_i);
        if (raddr_a_i == 3'd0) rdata_a_o = '0;
        else if (fwd_a)        rdata_a_o = wdata_i;
        else                   rdata_a_o = mem_q[raddr_a_i];
        if (raddr_b_i == 3'd0) rdata_b_o = '0;
        else if (fwd_b)        rdata_b_o = wdata_i;
        else                   rdata_b_o = mem_q[raddr_b_i];
    end

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: decodes instructions, reads operands, tracks in-flight
// destinations and holds one issue packet for the ALU.
module decode_issue_unit
    import isa_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BYPASS_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    decode_issue_unit_if.slave   bus
);

    logic [3:0]        op;
    logic [1:0]        typ;
    logic [2:0]        rd, ra, rb;
    use_t              use_s;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [7:0]        wb_hit, rd_block, rs_block;
    logic              hazard, ready, accept, issue_fire;

    logic              dec_valid_q, dec_valid_d;
    logic [3:0]        dec_op_q, dec_op_d;
    logic [1:0]        dec_type_q, dec_type_d;
    logic [DATA_W-1:0] dec_a_q, dec_a_d, dec_b_q, dec_b_d;
    logic [2:0]        dec_rd_q, dec_rd_d;
    logic              illegal_q, illegal_d;
    logic [7:0]        busy_q, busy_d;

    assign op    = bus.instr_i[OP_MSB:OP_LSB];
    assign typ   = bus.instr_i[TYPE_MSB:TYPE_LSB];
    assign rd    = bus.instr_i[RD_MSB:RD_LSB];
    assign ra    = bus.instr_i[RA_MSB:RA_LSB];
    assign rb    = bus.instr_i[RB_MSB:RB_LSB];
    assign use_s = decode_use(op);

    regfile_2r1w #(.DATA_W(DATA_W), .BYPASS_EN(BYPASS_EN)) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (bus.wb_en_i),
        .waddr_i   (bus.wb_addr_i),
        .wdata_i   (bus.wb_data_i),
        .raddr_a_i (ra),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rb),
        .rdata_b_o (rdata_b)
    );

    // With forwarding a register retiring this cycle is free; without it, any
    // source being written this cycle costs one stall cycle.
    always_comb begin
        wb_hit = '0;
        if (bus.wb_en_i && (bus.wb_addr_i != 3'd0)) wb_hit[bus.wb_addr_i] = 1'b1;
        rd_block = (BYPASS_EN != 0) ? (busy_q & ~wb_hit) : busy_q;
        rs_block = (BYPASS_EN != 0) ? rd_block : (busy_q | wb_hit);
        hazard   = use_s.issue && ((use_s.use_a && rs_block[ra]) ||
                                   (use_s.use_b && rs_block[rb]) || rd_block[rd]);
    end

    assign ready      = !bus.flush_i && !hazard && (!dec_valid_q || bus.dec_ready_i);
    assign accept     = bus.instr_valid_i && ready;
    assign issue_fire = accept && use_s.issue;

    always_comb begin
        dec_valid_d = dec_valid_q;
        dec_op_d    = dec_op_q;
        dec_type_d  = dec_type_q;
        dec_a_d     = dec_a_q;
        dec_b_d     = dec_b_q;
        dec_rd_d    = dec_rd_q;
        illegal_d   = accept && use_s.illegal;
        if (bus.flush_i) begin
            dec_valid_d = 1'b0;
        end else if (issue_fire) begin
            dec_valid_d = 1'b1;
            dec_op_d    = op;
            dec_type_d  = typ;
            dec_a_d     = use_s.use_a ? rdata_a : '0;
            dec_b_d     = use_s.use_b ? rdata_b : '0;
            dec_rd_d    = rd;
        end else if (bus.dec_ready_i) begin
            dec_valid_d = 1'b0;
        end
    end

    // Set is applied last so a same-cycle set/clear on one register keeps it busy.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (bus.flush_i && dec_valid_q) busy_d[dec_rd_q] = 1'b0;
        if (issue_fire) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_q <= 1'b0;
            dec_op_q    <= OP_NOP;
            dec_type_q  <= '0;
            dec_a_q     <= '0;
            dec_b_q     <= '0;
            dec_rd_q    <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            dec_valid_q <= dec_valid_d;
            dec_op_q    <= dec_op_d;
            dec_type_q  <= dec_type_d;
            dec_a_q     <= dec_a_d;
            dec_b_q     <= dec_b_d;
            dec_rd_q    <= dec_rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.instr_ready_o = ready;
    assign bus.dec_valid_o   = dec_valid_q;
    assign bus.dec_op_o      = dec_op_q;
    assign bus.dec_type_o    = dec_type_q;
    assign bus.dec_a_o       = dec_a_q;
    assign bus.dec_b_o       = dec_b_q;
    assign bus.dec_rd_o      = dec_rd_q;
    assign bus.illegal_o     = illegal_q;

endmodule

// File: tb/tb_decode_issue_unit.sv
// Bench for decode_issue_unit: directed sequences with a packet scoreboard fed at accept.
module tb_decode_issue_unit;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  typ;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
    } pkt_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    decode_issue_unit_if #(.DATA_W(DATA_W)) bus ();

    decode_issue_unit #(.DATA_W(DATA_W), .BYPASS_EN(1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    pkt_t        exp_q[$];
    logic [15:0] model [8];
    logic        exp_ill = 1'b0;
    int          checks = 0;
    int          errors = 0;
    pkt_t        mon_p;
    logic [3:0]  mon_op;
    logic        mon_acc;
    logic [40:0] snap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_model(input logic [2:0] addr);
        if (addr == 3'd0) return 16'h0;
        if (bus.wb_en_i && bus.wb_addr_i == addr) return bus.wb_data_i;
        return model[addr];
    endfunction

    function automatic logic [42:0] outs();
        return {bus.dec_valid_o, bus.illegal_o, bus.dec_op_o, bus.dec_type_o,
                bus.dec_a_o, bus.dec_b_o, bus.dec_rd_o};
    endfunction

    // Scoreboard monitor: sampled mid-cycle, reflects what the next rising edge will do.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) model[i] = 16'h0;
            exp_ill = 1'b0;
        end else begin
            chk("illegal_pulse", bus.illegal_o, exp_ill);
            mon_acc = bus.instr_valid_i && bus.instr_ready_o;
            mon_op  = bus.instr_i[15:12];
            exp_ill = mon_acc && (mon_op >= 4'hB) && (mon_op <= 4'hE);
            if (bus.dec_valid_o && bus.flush_i) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (bus.dec_valid_o && bus.dec_ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_pkt", 1, 0);
                else begin
                    mon_p = exp_q.pop_front();
                    chk("pkt", {bus.dec_op_o, bus.dec_type_o, bus.dec_a_o, bus.dec_b_o,
                                bus.dec_rd_o}, mon_p);
                end
            end
            if (mon_acc && mon_op <= 4'hA) begin
                mon_p.op  = mon_op;
                mon_p.typ = bus.instr_i[11:10];
                mon_p.rd  = bus.instr_i[9:7];
                mon_p.a   = (mon_op <= 4'h9) ? rd_model(bus.instr_i[6:4]) : 16'h0;
                mon_p.b   = (mon_op <= 4'h6 || mon_op == 4'hA) ? rd_model(bus.instr_i[3:1]) : 16'h0;
                exp_q.push_back(mon_p);
            end
            if (bus.wb_en_i && bus.wb_addr_i != 3'd0) model[bus.wb_addr_i] = bus.wb_data_i;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [15:0] data);
        bus.wb_en_i = 1'b1; bus.wb_addr_i = addr; bus.wb_data_i = data;
        cyc();
        bus.wb_en_i = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        bus.instr_i = ins;
        bus.instr_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (bus.instr_ready_o) begin
                cyc();
                bus.instr_valid_i = 1'b0;
                return;
            end
            cyc();
        end
        chk("issue_timeout", 0, 1);
        bus.instr_valid_i = 1'b0;
    endtask

    localparam logic [42:0] RST_OUTS = {1'b0, 1'b0, 4'hF, 2'b00, 16'h0, 16'h0, 3'h0};

    initial begin
        bus.flush_i = 0; bus.instr_valid_i = 0; bus.instr_i = 16'h0;
        bus.wb_en_i = 0; bus.wb_addr_i = 3'd0; bus.wb_data_i = 16'h0;
        bus.dec_ready_i = 1'b1;
        #23;
        chk("reset_outs", outs(), RST_OUTS);
        chk("reset_busy", dut.busy_q, 8'h00);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        cyc();

        // ADD r3,r1,r2 with r1=5, r2=3
        wb(3'd1, 16'd5);
        wb(3'd2, 16'd3);
        issue(16'h0194);
        @(negedge clk_i);
        chk("add_valid", bus.dec_valid_o, 1);
        chk("add_busy3", dut.busy_q[3], 1);
        cyc();

        // SUB r4,r3,r1 stalls on r3 until its writeback, then forwards 8
        bus.instr_i = 16'h1232; bus.instr_valid_i = 1'b1;
        @(negedge clk_i); chk("raw_stall0", bus.instr_ready_o, 0);
        cyc();
        @(negedge clk_i); chk("raw_stall1", bus.instr_ready_o, 0);
        cyc();
        bus.wb_en_i = 1'b1; bus.wb_addr_i = 3'd3; bus.wb_data_i = 16'd8;
        @(negedge clk_i); chk("bypass_ready", bus.instr_ready_o, 1);
        cyc();
        bus.instr_valid_i = 1'b0; bus.wb_en_i = 1'b0;
        @(negedge clk_i); chk("busy_after_sub", dut.busy_q, 8'h10);
        cyc();

        // backpressure: OR r6,r1,r2 held while XOR r7,r2,r1 waits
        bus.dec_ready_i = 1'b0;
        issue(16'h3314);
        bus.instr_i = 16'h43A2; bus.instr_valid_i = 1'b1;
        @(negedge clk_i);
        chk("bp_valid", bus.dec_valid_o, 1);
        snap = {bus.dec_op_o, bus.dec_type_o, bus.dec_a_o, bus.dec_b_o, bus.dec_rd_o};
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk_i);
            chk("bp_stable", {bus.dec_valid_o, bus.dec_op_o, bus.dec_type_o, bus.dec_a_o,
                              bus.dec_b_o, bus.dec_rd_o}, {1'b1, snap});
            chk("bp_ready", bus.instr_ready_o, 0);
        end
        cyc();
        bus.dec_ready_i = 1'b1;
        @(negedge clk_i); chk("bp_release_ready", bus.instr_ready_o, 1);
        cyc();
        bus.instr_valid_i = 1'b0;
        @(negedge clk_i); chk("bp_next_valid", bus.dec_valid_o, 1);
        cyc();

        // illegal op 0xC then NOP
        issue(16'hC000);
        @(negedge clk_i);
        chk("ill_no_pkt", bus.dec_valid_o, 0);
        chk("ill_busy", dut.busy_q, 8'hD0);
        cyc();
        issue(16'hF000);
        @(negedge clk_i); chk("nop_no_pkt", bus.dec_valid_o, 0);
        cyc();
        @(negedge clk_i); chk("nop_busy", dut.busy_q, 8'hD0);
        cyc();

        // flush of held ADD r5
        bus.dec_ready_i = 1'b0;
        issue(16'h0294);
        bus.flush_i = 1'b1; bus.instr_i = 16'h0194; bus.instr_valid_i = 1'b1;
        @(negedge clk_i);
        chk("flush_ready", bus.instr_ready_o, 0);
        chk("flush_busy5_pre", dut.busy_q[5], 1);
        cyc();
        bus.flush_i = 1'b0; bus.instr_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_valid", bus.dec_valid_o, 0);
        chk("flush_busy", dut.busy_q, 8'hD0);
        chk("flush_queue", exp_q.size(), 0);
        cyc();

        // r0 write ignored; OR r1,r0,r0 gives zeros
        bus.dec_ready_i = 1'b1;
        wb(3'd0, 16'hFFFF);
        issue(16'h3080);
        @(negedge clk_i); chk("r0_busy", dut.busy_q, 8'hD2);
        cyc();

        // reset while a packet is held and a RAW hazard stalls
        bus.dec_ready_i = 1'b0;
        issue(16'hA184);
        bus.instr_i = 16'h0294; bus.instr_valid_i = 1'b1;
        @(negedge clk_i); chk("pre_rst_stall", bus.instr_ready_o, 0);
        cyc();
        #1;
        rst_ni = 1'b0; bus.instr_valid_i = 1'b0; bus.dec_ready_i = 1'b1;
        #1;
        chk("midrst_outs", outs(), RST_OUTS);
        chk("midrst_busy", dut.busy_q, 8'h00);
        cyc();
        rst_ni = 1'b1;
        cyc();
        issue(16'h0194);
        for (int i = 0; i < 3; i++) cyc();
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_unit.md
Name: decode_issue_unit

Overview:
- Decode/issue stage directly upstream of the execute-stage ALU.
- Accepts 16-bit instruction words and decodes op/type/register fields.
- Reads two operands from an internal 8x16 register file, with a writeback port and same-cycle bypass.
- Tracks in-flight destinations in a scoreboard, stalls on hazards, and presents one registered issue packet to the ALU over a valid/ready handshake.

Parameters:
- DATA_W, 16, operand and register width.
- BYPASS_EN, 1, 1 = writeback data forwarded to same-cycle operand reads; 0 = stall one cycle instead.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  discard the held issue packet.
- instr_valid_i  in  1  upstream instruction valid.
- instr_i  in  16  instruction word.
- instr_ready_o  out  1  instruction accepted when valid & ready.
- wb_en_i  in  1  register write strobe from writeback.
- wb_addr_i  in  3  register written.
- wb_data_i  in  DATA_W  write data.
- dec_valid_o  out  1  issue packet valid.
- dec_ready_i  in  1  ALU consumes the packet when valid & ready.
- dec_op_o  out  4  ALU op.
- dec_type_o  out  2  ALU type.
- dec_a_o  out  DATA_W  operand A.
- dec_b_o  out  DATA_W  operand B.
- dec_rd_o  out  3  destination register.
- illegal_o  out  1  one-cycle pulse, illegal opcode dropped.

Behaviour:
- Instruction format: [15:12] op, [11:10] type, [9:7] rd, [6:4] ra, [3:1] rb, [0] reserved (ignored).
- Operand use by op:
  - 0x0-0x6 read ra and rb.
  - 0x7-0x9 read ra only; dec_b_o = 0.
  - 0xA reads rb only; dec_a_o = 0.
  - 0xB-0xE illegal.
  - 0xF NOP.
- Register file: 8 entries. r0 always reads 0, and writes to r0 are ignored. Write occurs on the edge when wb_en_i = 1.
- Scoreboard: busy[7:0]. r0 is never busy.
  - Set on accept of a non-NOP, legal instruction with rd != 0.
  - Cleared on wb_en_i for that register.
  - Set and clear on the same reg in the same cycle: set wins.
- Hazard (combinational) when any read register, or rd (WAW), is busy.
  - Exception: a busy bit being cleared this cycle by wb_en_i does not cause a hazard when BYPASS_EN = 1.
- instr_ready_o = !flush_i & !hazard & (!dec_valid_o | dec_ready_i).
- On accept, the packet is registered next edge; latency is 1 cycle instr_i -> dec_valid_o.
- NOP: consumed; no packet is produced and dec_valid_o stays 0 unless an older packet is held.
- Illegal op: consumed and dropped; illegal_o = 1 the following cycle; scoreboard unchanged.
- Bypass: a read address equal to wb_addr_i with wb_en_i = 1 (addr != 0) returns wb_data_i.
- Backpressure: while dec_valid_o & !dec_ready_i, all dec_*_o are held stable and instr_ready_o = 0.
- Flush:
  - dec_valid_o clears next edge.
  - If the flushed packet was valid with rd != 0, busy[rd] is cleared.
  - No input is accepted that cycle.
  - A same-cycle wb_en_i is still applied.
- Reset (asynchronous assert, synchronous release):
  - dec_valid_o = 0, illegal_o = 0, busy = 0.
  - dec_op_o = 0xF, all other dec_*_o = 0.
  - Register file contents = 0.
  - Reset mid-stall drops every in-flight item.

Decomposition:
- Shared package isa_pkg:
  - Opcode localparams (OP_ADD..OP_PB, OP_NOP = 4'hF).
  - Type codes (TYPE_SIGNED = 0, TYPE_BYTE = 1).
  - Instruction field bit positions.
  - Operand-use decode function, reused by execute.
- One sub-module regfile_2r1w: 8xDATA_W register file with two asynchronous read ports, one write port, r0 = 0 and optional bypass.
- Scoreboard and handshake logic stay in the top.

Test Plan:
- Reset, then load r1 = 5 and r2 = 3 via wb, then issue ADD r3,r1,r2 (0x0_0_3_1_2) -> one cycle later dec_valid_o = 1, op = 0, a = 5, b = 3, rd = 3, busy[3] = 1.
- Issue ADD r3,...; next instr SUB r4,r3,r1 -> instr_ready_o = 0 until wb_en_i for r3 with data 8. Bypass accepts in the same cycle, giving a = 8, b = 5.
- Hold dec_ready_i = 0 for 4 cycles with a valid packet -> dec_* outputs are stable, instr_ready_o = 0. Raise ready -> the next instruction issues the following cycle.
- Op 0xC -> no dec_valid_o, illegal_o pulses for exactly 1 cycle, busy unchanged. Op 0xF -> no output, no pulse.
- Held packet rd = 5 with flush_i = 1 -> dec_valid_o = 0 next cycle, busy[5] = 0, input not accepted that cycle.
- Write to r0 = 0xFFFF, then issue OR r1,r0,r0 -> a = b = 0. Assert rst_ni low while stalled -> all outputs take their reset values immediately.
